muldiv_unit: RTL and testbench

- Iterative multiply/divide execution unit for the RV64 M extension (MUL*, DIV*, REM*, including the *W forms), placed beside the ALU in the execute stage.
- Owns a one-operation-at-a-time handshake: it accepts one operation and raises busy_o so the hazard unit stalls the pipeline.
- Sequences a shared shift-add / restoring-subtract datapath through a small FSM.
- Returns the result with a one-cycle done_o pulse.

---
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64 M-extension multiply/divide unit.
// One 2*XLEN accumulator is shared by shift-add multiply and restoring divide.
module muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SPECIAL = 3'd1;
   localparam logic [2:0] S_ITER    = 3'd2;
   localparam logic [2:0] S_FIX     = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
      return XLEN'(signed'(x[31:0]));
   endfunction

   logic [2:0]        state_r;
   logic [2:0]        f3_r;
   logic              word_r;
   logic              neg_r;
   logic [CW-1:0]     cnt_r;
   logic [XLEN-1:0]   op_r;
   logic [XLEN-1:0]   sh_r;
   logic [2*XLEN-1:0] acc_r;

   logic [2:0]        eff_f3_s;
   logic              is_div_s;
   logic              signed_a_s;
   logic              signed_b_s;
   logic [XLEN-1:0]   a_n_s;
   logic [XLEN-1:0]   b_n_s;
   logic              sign_a_s;
   logic              sign_b_s;
   logic [XLEN-1:0]   mag_a_s;
   logic [XLEN-1:0]   mag_b_s;
   logic [XLEN-1:0]   al_a_s;
   logic [XLEN-1:0]   al_b_s;
   logic              neg_s;
   logic              div_zero_s;
   logic              div_ovf_s;
   logic              special_s;
   logic [XLEN-1:0]   dvd_ext_s;
   logic [XLEN-1:0]   special_val_s;

   // Operand decode at acceptance: word forms are pre-aligned to the MSB so iteration is width-agnostic.
   always_comb begin
      eff_f3_s   = (word_i && !funct3_i[2]) ? 3'b000 : funct3_i;
      is_div_s   = eff_f3_s[2];
      signed_a_s = is_div_s ? !eff_f3_s[0] : ((eff_f3_s == 3'b001) || (eff_f3_s == 3'b010));
      signed_b_s = is_div_s ? !eff_f3_s[0] : (eff_f3_s == 3'b001);
      a_n_s      = word_i ? (signed_a_s ? sext32(a_i) : XLEN'(a_i[31:0])) : a_i;
      b_n_s      = word_i ? (signed_b_s ? sext32(b_i) : XLEN'(b_i[31:0])) : b_i;
      sign_a_s   = signed_a_s && a_n_s[XLEN-1];
      sign_b_s   = signed_b_s && b_n_s[XLEN-1];
      mag_a_s    = sign_a_s ? (ZERO - a_n_s) : a_n_s;
      mag_b_s    = sign_b_s ? (ZERO - b_n_s) : b_n_s;
      al_a_s     = word_i ? (mag_a_s << 6'd32) : mag_a_s;
      al_b_s     = word_i ? (mag_b_s << 6'd32) : mag_b_s;
      neg_s      = (is_div_s && eff_f3_s[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
      div_zero_s = word_i ? (b_i[31:0] == 32'h0000_0000) : (b_i == ZERO);
      div_ovf_s  = !eff_f3_s[0] &&
                   (word_i ? ((a_i[31:0] == 32'h8000_0000) && (b_i[31:0] == 32'hFFFF_FFFF))
                           : ((a_i == MIN_NEG) && (b_i == ALL_ONES)));
      special_s  = is_div_s && (div_zero_s || div_ovf_s);
      dvd_ext_s  = word_i ? sext32(a_i) : a_i;
      if (div_zero_s) begin
         special_val_s = eff_f3_s[1] ? dvd_ext_s : ALL_ONES;
      end else begin
         special_val_s = eff_f3_s[1] ? ZERO : dvd_ext_s;
      end
   end

   logic [2*XLEN-1:0] mul_next_s;
   logic [XLEN:0]     top_s;
   logic [XLEN+1:0]   diff_s;
   logic              ge_s;
   logic [XLEN-1:0]   new_rem_s;
   logic [2*XLEN-1:0] div_next_s;
   logic [CW-1:0]     last_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   fix_raw_s;
   logic [XLEN-1:0]   fix_val_s;

   // One iteration step for each operation and the final sign/width correction.
   always_comb begin
      mul_next_s = {acc_r[2*XLEN-2:0], 1'b0} +
                   (sh_r[XLEN-1] ? {ZERO, op_r} : {ZERO, ZERO});
      top_s      = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      diff_s     = {1'b0, top_s} - {2'b00, op_r};
      ge_s       = !diff_s[XLEN+1];
      new_rem_s  = ge_s ? diff_s[XLEN-1:0] : top_s[XLEN-1:0];
      div_next_s = {new_rem_s, acc_r[XLEN-2:0], ge_s};
      last_s     = word_r ? CW'(31) : CW'(XLEN-1);
      prod_s     = neg_r ? ({ZERO, ZERO} - acc_r) : acc_r;
      quo_s      = neg_r ? (ZERO - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      rem_s      = neg_r ? (ZERO - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
      if (f3_r[2]) begin
         fix_raw_s = f3_r[1] ? rem_s : quo_s;
      end else begin
         fix_raw_s = (f3_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      end
      fix_val_s  = word_r ? sext32(fix_raw_s) : fix_raw_s;
   end

   // Control FSM and datapath registers; flush drops any in-flight operation silently.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r  <= S_IDLE;
         f3_r     <= 3'b000;
         word_r   <= 1'b0;
         neg_r    <= 1'b0;
         cnt_r    <= {CW{1'b0}};
         op_r     <= ZERO;
         sh_r     <= ZERO;
         acc_r    <= {ZERO, ZERO};
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         result_o <= ZERO;
      end else begin
         done_o <= 1'b0;
         if (flush_i && (state_r != S_IDLE)) begin
            state_r <= S_IDLE;
            busy_o  <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (start_i && !flush_i) begin
                     f3_r   <= eff_f3_s;
                     word_r <= word_i;
                     neg_r  <= neg_s;
                     cnt_r  <= {CW{1'b0}};
                     busy_o <= 1'b1;
                     if (is_div_s) begin
                        op_r  <= mag_b_s;
                        sh_r  <= ZERO;
                        acc_r <= special_s ? {ZERO, special_val_s} : {ZERO, al_a_s};
                     end else begin
                        op_r  <= mag_a_s;
                        sh_r  <= al_b_s;
                        acc_r <= {ZERO, ZERO};
                     end
                     state_r <= special_s ? S_SPECIAL : S_ITER;
                  end else begin
                     busy_o <= 1'b0;
                  end
               end
               S_SPECIAL: begin
                  result_o <= acc_r[XLEN-1:0];
                  done_o   <= 1'b1;
                  state_r  <= S_DONE;
               end
               S_ITER: begin
                  acc_r <= f3_r[2] ? div_next_s : mul_next_s;
                  sh_r  <= {sh_r[XLEN-2:0], 1'b0};
                  cnt_r <= cnt_r + CW'(1);
                  if (cnt_r == last_s) begin
                     state_r <= S_FIX;
                  end else begin
                     state_r <= S_ITER;
                  end
               end
               S_FIX: begin
                  result_o <= fix_val_s;
                  done_o   <= 1'b1;
                  state_r  <= S_DONE;
               end
               S_DONE: begin
                  busy_o  <= 1'b0;
                  state_r <= S_IDLE;
               end
               default: begin
                  busy_o  <= 1'b0;
                  state_r <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results and done cycles,
// an independent monitor pops and compares on every done_o pulse.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic        word;
   logic [63:0] a;
   logic [63:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int total;
   int passed;
   int cyc;

   logic [63:0] exp_q[$];
   int          cyc_q[$];
   string       name_q[$];

   muldiv_unit #(.XLEN(64)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .funct3_i (funct3),
      .word_i   (word),
      .a_i      (a),
      .b_i      (b),
      .flush_i  (flush),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      total = total + 1;
      if (act === exp_v) begin
         passed = passed + 1;
      end else begin
         $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [63:0] ev;
            int          ec;
            string       en;
            ev = exp_q.pop_front();
            ec = cyc_q.pop_front();
            en = name_q.pop_front();
            check({en, "_result"}, result, ev);
            check({en, "_done_cycle"}, 64'(cyc), 64'(ec));
         end
      end
   end

   task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] ev, input int lat,
                         input string nm);
      int k;
      bit busy_ok;
      @(negedge clk);
      funct3 = f3;
      word   = w;
      a      = av;
      b      = bv;
      start  = 1'b1;
      k      = cyc;
      exp_q.push_back(ev);
      cyc_q.push_back(k + lat);
      name_q.push_back(nm);
      busy_ok = 1'b1;
      for (int i = 1; i <= lat; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      check({nm, "_busy_window"}, 64'(busy_ok), 64'd1);
      @(negedge clk);
      check({nm, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   // Start a MUL, inject an ignored start, then abort at the 10th ITER cycle.
   task automatic abort_seq(input bit use_rst, input logic [63:0] prev_res);
      @(negedge clk);
      funct3 = 3'b000;
      word   = 1'b0;
      a      = 64'd123;
      b      = 64'd456;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      a     = 64'd9;
      b     = 64'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check(use_rst ? "rst_busy_before" : "flush_busy_before", 64'(busy), 64'd1);
      if (use_rst) rst = 1'b1;
      else         flush = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      flush = 1'b0;
      check(use_rst ? "rst_busy_after" : "flush_busy_after", 64'(busy), 64'd0);
      check(use_rst ? "rst_done_after" : "flush_done_after", 64'(done), 64'd0);
      check(use_rst ? "rst_result" : "flush_result", result, prev_res);
      repeat (80) @(negedge clk);
      check(use_rst ? "rst_idle_busy" : "flush_idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      total  = 0;
      passed = 0;
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      funct3 = 3'b000;
      word   = 1'b0;
      a      = 64'd0;
      b      = 64'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_result", result, 64'd0);
      rst = 1'b0;

      run_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, "mul");
      run_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div");
      run_op(3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem");
      run_op(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE, 66, "mulhu");
      run_op(3'b001, 1'b0, 64'hC000_0000_0000_0000, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulh");
      run_op(3'b010, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, "mulhsu");
      run_op(3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "divu_zero");
      run_op(3'b111, 1'b0, 64'h1234, 64'd0, 64'h1234, 2, "remu_zero");
      run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 2, "div_ovf");
      run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, "rem_ovf");
      run_op(3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 2, "divw_ovf");
      run_op(3'b110, 1'b1, 64'h0000_0005_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw");
      run_op(3'b101, 1'b1, 64'h0000_0001_0000_0010, 64'd3, 64'd5, 34, "divuw");
      run_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, "mulw");

      // A start coinciding with flush in IDLE must not be accepted.
      @(negedge clk);
      funct3 = 3'b000;
      a      = 64'd1;
      b      = 64'd1;
      start  = 1'b1;
      flush  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("start_flush_idle_busy", 64'(busy), 64'd0);

      abort_seq(1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 66, "mul_after_flush");
      abort_seq(1'b1, 64'd0);
      run_op(3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 66, "mul_after_rst");

      repeat (5) @(negedge clk);
      check("pending_expectations", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
